// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter for one SRAM port, with a built-in
// clear engine that fills the first DEPTH words with a constant.
module sram_port_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 131072
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] m0_address_i,
  input  logic              m0_read_i,
  input  logic              m0_write_i,
  input  logic [DATA_W-1:0] m0_writedata_i,
  output logic              m0_waitrequest_o,
  output logic [DATA_W-1:0] m0_readdata_o,
  output logic              m0_readdatavalid_o,
  input  logic [ADDR_W-1:0] m1_address_i,
  input  logic              m1_read_i,
  input  logic              m1_write_i,
  input  logic [DATA_W-1:0] m1_writedata_i,
  output logic              m1_waitrequest_o,
  output logic [DATA_W-1:0] m1_readdata_o,
  output logic              m1_readdatavalid_o,
  input  logic              clr_start_i,
  input  logic [DATA_W-1:0] clr_value_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic [ADDR_W-1:0] sram_address_o,
  output logic              sram_chipselect_o,
  output logic              sram_write_o,
  output logic [DATA_W-1:0] sram_writedata_o,
  output logic              sram_clken_o,
  input  logic [DATA_W-1:0] sram_readdata_i
);

  // state | meaning
  // IDLE  | requesters arbitrated, one access per cycle
  // CLEAR | clear engine writes counter address every cycle
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [DATA_W-1:0] clr_val_q;
  logic              last_grant_q;
  logic              rd_pend0_q, rd_pend1_q;
  logic              rd_pend0_d, rd_pend1_d;
  logic              clr_done_q;
  logic              req0, req1, grant0, grant1;

  assign req0 = m0_read_i | m0_write_i;
  assign req1 = m1_read_i | m1_write_i;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset_i && state_q == IDLE) begin
      if (req0 && req1) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  // Read+write together counts as a write and returns no data.
  assign rd_pend0_d = grant0 & m0_read_i & ~m0_write_i;
  assign rd_pend1_d = grant1 & m1_read_i & ~m1_write_i;

  always_comb begin
    sram_address_o    = '0;
    sram_chipselect_o = 1'b0;
    sram_write_o      = 1'b0;
    sram_writedata_o  = '0;
    if (!reset_i) begin
      if (state_q == CLEAR) begin
        sram_address_o    = cnt_q;
        sram_chipselect_o = 1'b1;
        sram_write_o      = 1'b1;
        sram_writedata_o  = clr_val_q;
      end else if (grant0) begin
        sram_address_o    = m0_address_i;
        sram_chipselect_o = 1'b1;
        sram_write_o      = m0_write_i;
        sram_writedata_o  = m0_writedata_i;
      end else if (grant1) begin
        sram_address_o    = m1_address_i;
        sram_chipselect_o = 1'b1;
        sram_write_o      = m1_write_i;
        sram_writedata_o  = m1_writedata_i;
      end
    end
  end

  assign sram_clken_o       = sram_chipselect_o;
  assign m0_waitrequest_o   = req0 & ~grant0;
  assign m1_waitrequest_o   = req1 & ~grant1;
  assign m0_readdatavalid_o = rd_pend0_q & ~reset_i;
  assign m1_readdatavalid_o = rd_pend1_q & ~reset_i;
  assign m0_readdata_o      = reset_i ? '0 : sram_readdata_i;
  assign m1_readdata_o      = reset_i ? '0 : sram_readdata_i;
  assign clr_busy_o         = (state_q == CLEAR);
  assign clr_done_o         = clr_done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clr_val_q    <= '0;
      last_grant_q <= 1'b1;
      rd_pend0_q   <= 1'b0;
      rd_pend1_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
      clr_done_q <= 1'b0;
      if (grant0) begin
        last_grant_q <= 1'b0;
      end else if (grant1) begin
        last_grant_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (clr_start_i) begin
            clr_val_q <= clr_value_i;
            cnt_q     <= '0;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            cnt_q      <= '0;
            clr_done_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one port of the 128K x 8 dual-port on-chip SRAM between two Avalon-MM style requesters, e.g. the video-in pixel writer and the DDA plot writer. A built-in clear engine fills the whole memory with a constant. The block sits between the requesters and the SRAM's second port (address2/chipselect2/write2/writedata2/clken2/readdata2). The first port stays with the HPS/bus slave.

## Interface
Parameters:
- ADDR_W, 17, SRAM address width
- DATA_W, 8, SRAM data width
- DEPTH, 131072, words cleared by the clear engine; must be at most 2^ADDR_W

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  requester 0 word address
- m0_read  in  1  requester 0 read request
- m0_write  in  1  requester 0 write request
- m0_writedata  in  DATA_W  requester 0 write data
- m0_waitrequest  out  1  request not accepted this cycle; hold request
- m0_readdata  out  DATA_W  read data to requester 0
- m0_readdatavalid  out  1  m0_readdata valid
- m1_*  same set as m0_*, for requester 1
- clr_start  in  1  start a full-memory clear (level; sampled in IDLE)
- clr_value  in  DATA_W  fill value, latched on accepted clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- sram_address  out  ADDR_W  to SRAM address2
- sram_chipselect  out  1  to chipselect2
- sram_write  out  1  to write2
- sram_writedata  out  DATA_W  to writedata2
- sram_clken  out  1  to clken2; equals sram_chipselect
- sram_readdata  in  DATA_W  from readdata2

## Operation
- FSM states:
  - IDLE: arbitrate requesters.
  - CLEAR: the clear engine owns the port.
- IDLE arbitration (combinational grant, at most one access per cycle):
  - req_n = mn_read | mn_write.
  - If only one requester has req_n, it is granted.
  - If both request, grant goes to the requester not in last_grant (round-robin).
  - last_grant updates to the granted index on every grant.
- mn_waitrequest = req_n & ~grant_n. In CLEAR, waitrequest = req_n for both requesters.
- Granted access drives sram_address = mn_address and sram_chipselect = 1.
  - sram_write = mn_write; sram_writedata = mn_writedata.
  - mn_read and mn_write high together are treated as a write; no read data is returned.
- Read return:
  - A granted read sets rd_pend_n for one cycle.
  - Next cycle: mn_readdatavalid = 1 and mn_readdata = sram_readdata.
  - Both m0_readdata and m1_readdata carry sram_readdata. Only the owner's readdatavalid is asserted.
- No grant: sram_chipselect = 0, sram_write = 0, sram_address = 0, sram_writedata = 0.
- Clear engine:
  - clr_start high in IDLE: latch clr_value. That same cycle is still arbitrated normally. Enter CLEAR next cycle with counter = 0.
  - Each CLEAR cycle: sram_address = counter, sram_write = 1, sram_chipselect = 1, sram_writedata = latched value, counter++.
  - After the write at DEPTH-1: return to IDLE and pulse clr_done in the first IDLE cycle.
  - clr_start while in CLEAR is ignored. clr_start held high re-triggers a new clear on the first IDLE cycle after clr_done.
  - clr_busy = (state == CLEAR).
- A read granted in the cycle clr_start is accepted still returns readdatavalid in the first CLEAR cycle.

## Timing
- Write: accepted in the grant cycle (waitrequest low); SRAM writes on that edge.
- Read latency: exactly 1 cycle from grant to readdatavalid. The SRAM output is unregistered.
- Throughput: one access per cycle. Two continuous requesters alternate grants every cycle.
- Clear: DEPTH cycles of writes. clr_busy is high for exactly DEPTH cycles. clr_done is high on cycle DEPTH+1 after acceptance.
- Reset (synchronous):
  - State = IDLE; counter = 0; last_grant = 1, so m0 wins the first tie.
  - rd_pend = 0, clr_busy = 0, clr_done = 0, readdatavalid = 0, readdata = 0.
  - All sram_* outputs = 0.
  - While reset is high, no grant; waitrequest = req_n.
- Reset mid-clear: abort immediately, no clr_done. Memory is partially cleared.
- Reset with a read pending: readdatavalid is not asserted.

## Test plan
- Single read: m0 writes 0x5A at 0x00010, then reads 0x00010 -> waitrequest 0 both cycles; m0_readdatavalid = 1 with 0x5A exactly one cycle after the read grant; m1_readdatavalid stays 0.
- Contention: m0 and m1 both hold writes to 0x00100/0x00200 for 4 cycles after reset -> grants m0, m1, m0, m1; each waitrequest is high on alternate cycles.
- Write+read collision: m1 asserts read and write together to 0x1FFFF with data 0x33 -> a write occurs; no readdatavalid; a later read returns 0x33.
- Clear: DEPTH = 16 build, clr_start with clr_value 0xA5 -> clr_busy high 16 cycles, addresses 0..15 written; clr_done one pulse; m0 requests during clear see waitrequest = 1; reads of 0..15 afterwards return 0xA5.
- Clear with read in flight: m0 read granted in the clr_start cycle -> m0_readdatavalid in the first CLEAR cycle; the clear still writes all addresses.
- Reset mid-clear at counter 7 -> clr_busy 0 next cycle, no clr_done; addresses 8..15 unchanged.
